// File: rtl/m_counter_seq.sv
// Command sequencer feeding S/EN/IN of an 8-bit up/down counter.
// One command at a time; count steps paced by a prescaler, RCO watched for wrap.
module m_counter_seq #(
   parameter int PRESC_W = 16,
   parameter int DATA_W  = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_op_i,
   input  logic [DATA_W-1:0]  cmd_arg_i,
   input  logic [PRESC_W-1:0] presc_i,
   input  logic               abort_i,
   input  logic               rco_i,
   output logic [1:0]         s_o,
   output logic               en_o,
   output logic [DATA_W-1:0]  in_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  steps_left_o,
   output logic               wrap_o
);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_APPLY  = 2'b01;
   localparam logic [1:0] ST_RUN    = 2'b10;
   localparam logic [1:0] ST_FINISH = 2'b11;

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_LD  = 2'b10;
   localparam logic [1:0] OP_UP  = 2'b11;
   localparam logic [1:0] S_HOLD = 2'b11;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [DATA_W-1:0]  arg_q, arg_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0]  steps_q, steps_d;
   logic               wrap_q, wrap_d;
   logic               step_due;

   assign step_due     = (state_q == ST_RUN) && (pc_q == presc_q);
   assign en_o         = step_due && !abort_i;
   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_FINISH);
   assign steps_left_o = steps_q;
   assign wrap_o       = wrap_q;

   // Only APPLY and RUN drive the latched op; everything else holds the counter.
   assign s_o  = (state_q == ST_APPLY || state_q == ST_RUN) ? op_q : S_HOLD;
   assign in_o = (state_q == ST_APPLY && op_q == OP_LD) ? arg_q : '0;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      arg_d   = arg_q;
      presc_d = presc_q;
      pc_d    = pc_q;
      steps_d = steps_q;
      wrap_d  = wrap_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               op_d    = cmd_op_i;
               arg_d   = cmd_arg_i;
               presc_d = presc_i;
               pc_d    = '0;
               wrap_d  = 1'b0;
               if (!cmd_op_i[0]) begin
                  state_d = ST_APPLY;
               end else begin
                  steps_d = cmd_arg_i;
                  state_d = (cmd_arg_i != '0) ? ST_RUN : ST_FINISH;
               end
            end
         end
         ST_APPLY: begin
            state_d = ST_FINISH;
         end
         ST_RUN: begin
            if (abort_i) begin
               state_d = ST_FINISH;
            end else if (step_due) begin
               pc_d = '0;
               if (steps_q != '0) begin
                  steps_d = steps_q - DATA_W'(1);
               end
               if (rco_i && op_q == OP_UP) begin
                  wrap_d = 1'b1;
               end
               if (steps_q <= DATA_W'(1)) begin
                  state_d = ST_FINISH;
               end
            end else begin
               pc_d = pc_q + PRESC_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_CLR;
         arg_q   <= '0;
         presc_q <= '0;
         pc_q    <= '0;
         steps_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         arg_q   <= arg_d;
         presc_q <= presc_d;
         pc_q    <= pc_d;
         steps_q <= steps_d;
         wrap_q  <= wrap_d;
      end
   end

endmodule
